// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point packing helpers for the MAC datapath.
//   BF16_EXP_W / BF16_MAN_W : default output format widths
//   fp_flags_t              : per-result status flags
//   fp_bias                 : exponent bias for a given exponent width
//   fp_pack                 : packs {sign, exp, frac} into the low bits of a word
//   fp_inf / fp_max_finite  : signed infinity and largest finite encodings
// Helpers return a fixed-width word so one function serves any format;
// callers keep the low 1+EXP_W+MAN_W bits.
package fp_pkg;

  localparam int unsigned BF16_EXP_W = 8;
  localparam int unsigned BF16_MAN_W = 7;
  localparam int unsigned FP_WORD_W  = 64;

  typedef logic [FP_WORD_W-1:0] fp_word_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  function automatic fp_word_t fp_field_mask(input int unsigned w);
    return (fp_word_t'(1) << w) - fp_word_t'(1);
  endfunction

  function automatic fp_word_t fp_pack(input int unsigned exp_w,
                                       input int unsigned man_w,
                                       input logic        sign,
                                       input fp_word_t    exp_f,
                                       input fp_word_t    frac_f);
    fp_word_t r;
    r = ((exp_f & fp_field_mask(exp_w)) << man_w) | (frac_f & fp_field_mask(man_w));
    r = r | (fp_word_t'(sign) << (exp_w + man_w));
    return r;
  endfunction

  function automatic fp_word_t fp_inf(input int unsigned exp_w,
                                      input int unsigned man_w,
                                      input logic        sign);
    return fp_pack(exp_w, man_w, sign, fp_field_mask(exp_w), '0);
  endfunction

  function automatic fp_word_t fp_max_finite(input int unsigned exp_w,
                                             input int unsigned man_w,
                                             input logic        sign);
    return fp_pack(exp_w, man_w, sign, fp_field_mask(exp_w) - fp_word_t'(1),
                   fp_field_mask(man_w));
  endfunction

endpackage

// File: rtl/fp_normalizer_pipe_lzc.sv
// lzc: purely combinational leading-zero counter.
//   value : input vector, MSB first
//   count : number of zeros above the most significant one (W when value==0)
module lzc #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]           value,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic found;

  always_comb begin
    count = CNT_W'(W);
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && value[W-1-i]) begin
        count = CNT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_normalizer_pipe.sv
// fp_normalizer_pipe: two-stage round-and-pack stage for the MAC datapath.
// Stage 1 normalises the raw mantissa (leading one to the MSB) and adjusts
// the exponent; stage 2 rounds to nearest-even and packs {sign, exp, frac}.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid / in_ready          : input handshake
//   in_sign, in_exp, in_mant     : sign, two's-complement biased exponent,
//                                  raw mantissa in [0,4) (point below bit RAW_W-2)
//   out_valid / out_ready        : output handshake
//   out_result                   : packed {sign, exp, frac}
//   out_overflow/underflow/inexact : per-beat status, valid with out_valid
// Build option: define FP_NORM_SAT_EN to saturate overflow to the largest
// finite value instead of producing infinity.
module fp_normalizer_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = BF16_EXP_W,
  parameter int unsigned MAN_W = BF16_MAN_W,
  parameter int unsigned RAW_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W+1:0]       in_exp,
  input  logic [RAW_W-1:0]       in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic                   out_inexact
);

  localparam int unsigned CNT_W = $clog2(RAW_W + 1);
  localparam int unsigned E_W   = EXP_W + 2;
  localparam int unsigned X_W   = EXP_W + 3;
  localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
  localparam logic [X_W-1:0] EXP_OVF = X_W'((1 << EXP_W) - 1);

  // Handshake
  logic s1_valid, s2_valid, adv1, adv2;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid;

  // Stage 1: normalise
  logic [CNT_W-1:0] lz;
  logic [RAW_W-1:0] mant_shl;
  logic [E_W-1:0]   exp_n;

  lzc #(.W(RAW_W)) u_lzc (
    .value (in_mant),
    .count (lz)
  );

  assign mant_shl = in_mant << lz;
  // Leading one at position p = RAW_W-1-lz, so exp + p - (RAW_W-2) = exp + 1 - lz.
  assign exp_n    = in_exp + E_W'(1) - E_W'(lz);

  logic             s1_sign, s1_zero;
  logic [E_W-1:0]   s1_exp;
  logic [RAW_W-2:0] s1_mant;  // hidden leading one dropped

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_zero <= (in_mant == '0);
        s1_exp  <= exp_n;
        s1_mant <= mant_shl[RAW_W-2:0];
      end
    end
  end

  // Stage 2: round to nearest even and pack
  logic [MAN_W-1:0] frac;
  logic             guard, sticky, round_up;
  logic [MAN_W:0]   frac_sum;
  logic [X_W-1:0]   exp_r;

  assign frac     = s1_mant[RAW_W-2 -: MAN_W];
  assign guard    = s1_mant[RAW_W-2-MAN_W];
  assign sticky   = |s1_mant[RAW_W-3-MAN_W:0];
  assign round_up = guard && (sticky || frac[0]);
  assign frac_sum = {1'b0, frac} + (MAN_W+1)'(round_up);
  // One extra exponent bit so the rounding carry cannot wrap the sign.
  assign exp_r    = {s1_exp[E_W-1], s1_exp} + X_W'(frac_sum[MAN_W]);

  fp_word_t  res_word;
  fp_flags_t flags_d;

  always_comb begin
    flags_d  = '0;
    res_word = fp_pack(EXP_W, MAN_W, s1_sign, fp_word_t'(exp_r),
                       fp_word_t'(frac_sum[MAN_W-1:0]));
    if (s1_zero) begin
      res_word = fp_pack(EXP_W, MAN_W, s1_sign, '0, '0);
    end else if (!exp_r[X_W-1] && (exp_r >= EXP_OVF)) begin
`ifdef FP_NORM_SAT_EN
      res_word = fp_max_finite(EXP_W, MAN_W, s1_sign);
`else
      res_word = fp_inf(EXP_W, MAN_W, s1_sign);
`endif
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
    end else if (exp_r[X_W-1] || (exp_r == '0)) begin
      res_word = fp_pack(EXP_W, MAN_W, s1_sign, '0, '0);
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end else begin
      flags_d.inexact = guard || sticky;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{res_word[FP_WORD_W-1:RES_W], mant_shl[RAW_W-1]};

  fp_flags_t s2_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      s2_flags   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_word[RES_W-1:0];
        s2_flags   <= flags_d;
      end
    end
  end

  assign out_overflow  = s2_flags.overflow;
  assign out_underflow = s2_flags.underflow;
  assign out_inexact   = s2_flags.inexact;

endmodule

// File: tb/tb_fp_normalizer_pipe.sv
module tb_fp_normalizer_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [15:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  int tests = 0;
  int fails = 0;

`ifdef FP_NORM_SAT_EN
  localparam logic [15:0] OVF_RES = 16'h7F7F;
`else
  localparam logic [15:0] OVF_RES = 16'h7F80;
`endif

  fp_normalizer_pipe #(.EXP_W(8), .MAN_W(7), .RAW_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [9:0]  e;
    logic [15:0] m;
    logic [15:0] r;
    logic [2:0]  f;  // {overflow, underflow, inexact}
  } vec_t;

  vec_t vecs[15];

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    tests++;
    if (out_result !== 16'h0000) begin fails++; $display("FAIL reset_result got=%h want=0000", out_result); end
    tests++;
    if ({out_overflow, out_underflow, out_inexact} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got=%b want=000", {out_overflow, out_underflow, out_inexact});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_vectors();
    vecs[0]  = '{1'b0, 10'd127,  16'h4000, 16'h3F80, 3'b000};
    vecs[1]  = '{1'b0, 10'd127,  16'h8000, 16'h4000, 3'b000};
    vecs[2]  = '{1'b0, 10'd127,  16'h2000, 16'h3F00, 3'b000};
    vecs[3]  = '{1'b0, 10'd127,  16'h4040, 16'h3F80, 3'b001};
    vecs[4]  = '{1'b0, 10'd127,  16'h40C0, 16'h3F82, 3'b001};
    vecs[5]  = '{1'b0, 10'd127,  16'h7FC0, 16'h4000, 3'b001};
    vecs[6]  = '{1'b0, 10'd254,  16'h8000, OVF_RES,  3'b101};
    vecs[7]  = '{1'b0, 10'd1,    16'h2000, 16'h0000, 3'b011};
    vecs[8]  = '{1'b1, 10'd127,  16'h0000, 16'h8000, 3'b000};
    vecs[9]  = '{1'b1, 10'd127,  16'h4000, 16'hBF80, 3'b000};
    vecs[10] = '{1'b1, 10'h3FB,  16'h4000, 16'h8000, 3'b011};
    vecs[11] = '{1'b0, 10'd141,  16'h0001, 16'h3F80, 3'b000};
    vecs[12] = '{1'b0, 10'd127,  16'h4041, 16'h3F81, 3'b001};
    vecs[13] = '{1'b0, 10'd253,  16'h8000, 16'h7F00, 3'b000};
    vecs[14] = '{1'b0, 10'd254,  16'h7FC0, OVF_RES,  3'b101};
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = vecs[i].s;
      in_exp   = vecs[i].e;
      in_mant  = vecs[i].m;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL vec%0d_in_ready got=%b want=1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL vec%0d_early_valid got=%b want=0", i, out_valid); end
      @(negedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL vec%0d_valid got=%b want=1", i, out_valid); end
      tests++;
      if (out_result !== vecs[i].r) begin
        fails++; $display("FAIL vec%0d_result got=%h want=%h", i, out_result, vecs[i].r);
      end
      tests++;
      if ({out_overflow, out_underflow, out_inexact} !== vecs[i].f) begin
        fails++; $display("FAIL vec%0d_flags got=%b want=%b", i,
                          {out_overflow, out_underflow, out_inexact}, vecs[i].f);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_sign = 1'b0;
    in_exp = 10'd127;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (c < 4);
      in_mant  = 16'h4000 + 16'(c * 128);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready c=%0d got=%b want=1", c, in_ready); end
      tests++;
      if (out_valid !== (c >= 2)) begin fails++; $display("FAIL b2b_valid c=%0d got=%b want=%b", c, out_valid, c >= 2); end
      if (c >= 2) begin
        tests++;
        if (out_result !== 16'h3F80 + 16'(c - 2)) begin
          fails++; $display("FAIL b2b_result c=%0d got=%h want=%h", c, out_result, 16'h3F80 + 16'(c - 2));
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int          sent = 0;
    int          rcvd = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_res = '0;
    logic        exp_rdy;
    in_sign = 1'b0;
    in_exp  = 10'd127;
    for (int cyc = 0; cyc < 200 && rcvd < 8; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && cyc < 7)  out_ready = 1'b0;
      else if (cyc > 40)        out_ready = 1'b1;
      else                      out_ready = 1'($urandom_range(0, 1));
      in_valid = (sent < 8);
      in_mant  = 16'h4000 + 16'(sent * 128);
      #1;
      // Two beats in flight means both stages are occupied.
      exp_rdy = !(((sent - rcvd) == 2) && !out_ready);
      tests++;
      if (in_ready !== exp_rdy) begin
        fails++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy);
      end
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || out_result !== prev_res) begin
          fails++; $display("FAIL bp_stable cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, out_result, prev_res);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (out_result !== 16'h3F80 + 16'(rcvd)) begin
          fails++; $display("FAIL bp_order beat=%0d got=%h want=%h", rcvd, out_result, 16'h3F80 + 16'(rcvd));
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (rcvd != 8 || sent != 8) begin
      fails++; $display("FAIL bp_count got=%0d/%0d want=8/8", sent, rcvd);
    end
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_duplicate got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_sign = 1'b0;
    in_exp = 10'd127;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mant  = 16'h4000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_inflight got=%b want=1", out_valid); end
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    tests++;
    if (out_result !== 16'h0000) begin fails++; $display("FAIL mid_rst_result got=%h want=0000", out_result); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_release_valid got=%b want=0", out_valid); end
    @(negedge clk);
    in_valid = 1'b1;
    in_mant  = 16'h8000;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale_valid got=%b want=0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_early_valid got=%b want=0", out_valid); end
    @(negedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_result !== 16'h4000) begin
      fails++; $display("FAIL mid_result got=%b/%h want=1/4000", out_valid, out_result);
    end
    @(negedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_drain got=%b want=0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_normalizer_pipe.md
Name: fp_normalizer_pipe

Overview:
- Parametrised, pipelined round-and-pack stage for the MAC datapath: takes sign, wide signed exponent and raw fixed-point mantissa from the multiplier/accumulator; emits a packed IEEE-style float (BF16 by default) plus status flags.
- Generalises the BF16 normaliser:
  - configurable exponent, mantissa and raw widths;
  - full leading-one normalisation in both directions;
  - round-to-nearest-even with guard/sticky;
  - valid/ready handshake through a 2-stage pipeline.

Parameters:
- EXP_W, 8, output exponent width; bias = 2^(EXP_W-1)-1.
- MAN_W, 7, stored fraction width of the output.
- RAW_W, 16, raw mantissa width; binary point between bit RAW_W-2 and RAW_W-3, so mant_raw is in [0,4). Must be >= MAN_W+3.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block can accept a beat.
- in_sign, in, 1, sign of result.
- in_exp, in, EXP_W+2, two's-complement biased exponent.
- in_mant, in, RAW_W, raw unsigned mantissa.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts.
- out_result, out, 1+EXP_W+MAN_W, packed {sign, exp, frac}.
- out_overflow, out, 1, result overflowed.
- out_underflow, out, 1, nonzero result flushed to zero.
- out_inexact, out, 1, rounding discarded nonzero bits.

Behaviour:
- Reset (async, active-high): both stage valids clear; out_valid=0; out_result=0; all flags 0; in_ready=1 on the first cycle after reset release. Reset mid-operation discards in-flight beats, with no partial output.
- Value convention: (-1)^s * in_mant * 2^-(RAW_W-2) * 2^(in_exp - bias).
- Latency: exactly 2 cycles from input acceptance to out_valid when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers on valid&&ready at either port.
  - Stage advance: adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational, no dependence on in_valid).
  - While out_valid && !out_ready, out_result and the flags hold stable.
  - Simultaneous output accept and input accept when full gives no bubble and no loss.
- Stage 1 (normalise):
  - Leading-one detect p on in_mant.
  - Left-shift so the leading one sits at bit RAW_W-1.
  - exp_n = in_exp + p - (RAW_W-2), at EXP_W+2 bits signed.
  - Register the zero flag when in_mant==0.
- Stage 2 (round/pack):
  - frac = the next MAN_W bits below the leading one; guard = the next bit; sticky = OR of all lower bits.
  - Round up if guard && (sticky || frac[0]).
  - Round carry out of frac: frac=0, exp_n+1.
  - inexact = guard|sticky.
- Packing, in priority order:
  - Zero input: {sign, all zeros}; no flags.
  - exp_n >= 2^EXP_W - 1: overflow → {sign, all-ones exp, frac 0}; out_overflow=1; out_inexact=1.
  - exp_n <= 0 (including negative): flush to {sign, 0}; out_underflow=1; out_inexact=1. Subnormals are not produced.
  - Otherwise: {sign, exp_n[EXP_W-1:0], frac}.
- Flags are per-beat and valid only with out_valid.

Optional Feature:
- FP_NORM_SAT_EN. When defined, overflow saturates to the largest finite value {sign, 2^EXP_W-2, all-ones frac} instead of infinity; out_overflow is still asserted.
- When undefined, overflow produces signed infinity.

Decomposition:
- Shared package fp_pkg holds:
  - constants: BF16_EXP_W=8, BF16_MAN_W=7, bias function;
  - typedef fp_flags_t {overflow, underflow, inexact};
  - pack function and the inf/max-finite constant functions.
- One sub-module, lzc (parametrised leading-zero counter, purely combinational), used by stage 1.

Test Plan (defaults; exp = in_exp):
- mant 16'h4000, exp 127 → 0x3F80; mant 16'h8000, exp 127 → 0x4000; mant 16'h2000, exp 127 → 0x3F00 (left-normalise). No flags.
- RNE ties: mant 16'h4040, exp 127 → 0x3F80 with inexact; mant 16'h40C0, exp 127 → 0x3F82 with inexact.
- Round carry: mant 16'h7FC0, exp 127 → 0x4000 with inexact.
- Overflow and underflow:
  - mant 16'h8000, exp 254 → 0x7F80 with overflow (0x7F7F under FP_NORM_SAT_EN).
  - mant 16'h2000, exp 1 → 0x0000 with underflow.
  - sign=1, mant 0 → 0x8000, no flags.
- Backpressure: stream 8 beats with out_ready toggling randomly (including 4 consecutive low cycles) → results in order, none dropped or duplicated, out_result stable while stalled, in_ready low only when both stages are full and out_ready=0.
- Assert rst mid-stream with 2 beats in flight → out_valid=0 immediately; after release the next beat emerges after exactly 2 cycles.
